// File: rtl/noc_run_monitor.sv
// Run supervisor: sums receive pulses, detects fabric stalls and enforces a cycle budget.
// Optional per-node receive counters are enabled with the NOC_MON_PER_NODE_EN macro.
module noc_run_monitor #(
  parameter int NODES_NUM      = 16,
  parameter int ACT_WIDTH      = 64,
  parameter int CNT_WIDTH      = 32,
  parameter int PACKS_EXPECTED = 64,
  parameter int STALL_LIMIT    = 10000,
  parameter int TEST_TIME      = 100000
) (
  input  logic                 clk,
  input  logic                 a_rst,
  input  logic                 start_i,
  input  logic                 clear_i,
  input  logic [NODES_NUM-1:0] recv_i,
  input  logic [ACT_WIDTH-1:0] act_i,
  output logic [CNT_WIDTH-1:0] total_o,
  output logic [CNT_WIDTH-1:0] cycles_o,
  output logic [2:0]           state_o,
  output logic                 done_o,
  output logic                 stalled_o,
  output logic                 timeout_o,
  output logic                 busy_o
`ifdef NOC_MON_PER_NODE_EN
  ,
  output logic [NODES_NUM*CNT_WIDTH-1:0] per_node_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_DONE    = 3'd2,
    S_STALLED = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] PACKS_LIM = CNT_WIDTH'(PACKS_EXPECTED);
  localparam logic [CNT_WIDTH-1:0] STALL_LIM = CNT_WIDTH'(STALL_LIMIT);
  localparam logic [CNT_WIDTH-1:0] TIME_LIM  = CNT_WIDTH'(TEST_TIME);

  // Counters clamp at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [CNT_WIDTH-1:0] b);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  state_t               r_state, w_state_nx;
  logic [CNT_WIDTH-1:0] r_total, w_total_nx;
  logic [CNT_WIDTH-1:0] r_cycles, w_cycles_nx;
  logic [CNT_WIDTH-1:0] r_stall, w_stall_nx;
  logic [ACT_WIDTH-1:0] r_act_q, w_act_q_nx;
  logic                 r_done, w_done_nx;
  logic                 r_stalled, w_stalled_nx;
  logic                 r_timeout, w_timeout_nx;
  logic                 r_busy, w_busy_nx;
  logic [CNT_WIDTH-1:0] w_pop;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NODES_NUM; i++) begin
      w_pop = w_pop + CNT_WIDTH'(recv_i[i]);
    end
  end

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      r_state   <= S_IDLE;
      r_total   <= '0;
      r_cycles  <= '0;
      r_stall   <= '0;
      r_act_q   <= '0;
      r_done    <= 1'b0;
      r_stalled <= 1'b0;
      r_timeout <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_total   <= w_total_nx;
      r_cycles  <= w_cycles_nx;
      r_stall   <= w_stall_nx;
      r_act_q   <= w_act_q_nx;
      r_done    <= w_done_nx;
      r_stalled <= w_stalled_nx;
      r_timeout <= w_timeout_nx;
      r_busy    <= w_busy_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_total_nx   = r_total;
    w_cycles_nx  = r_cycles;
    w_stall_nx   = r_stall;
    w_act_q_nx   = r_act_q;
    w_done_nx    = r_done;
    w_stalled_nx = r_stalled;
    w_timeout_nx = r_timeout;
    if (clear_i) begin
      w_state_nx   = S_IDLE;
      w_total_nx   = '0;
      w_cycles_nx  = '0;
      w_stall_nx   = '0;
      w_act_q_nx   = act_i;
      w_done_nx    = 1'b0;
      w_stalled_nx = 1'b0;
      w_timeout_nx = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_total_nx  = '0;
          w_cycles_nx = '0;
          w_stall_nx  = '0;
          w_act_q_nx  = act_i;
          if (start_i) w_state_nx = S_RUN;
        end
        S_RUN: begin
          w_total_nx  = sat_add(r_total, w_pop);
          w_cycles_nx = sat_add(r_cycles, CNT_ONE);
          if (act_i != r_act_q) begin
            w_stall_nx = '0;
            w_act_q_nx = act_i;
          end else begin
            w_stall_nx = sat_add(r_stall, CNT_ONE);
          end
          // Exit checks look at the values being written this edge.
          if (w_total_nx >= PACKS_LIM) begin
            w_state_nx = S_DONE;
            w_done_nx  = 1'b1;
          end else if (w_stall_nx == STALL_LIM) begin
            w_state_nx   = S_STALLED;
            w_stalled_nx = 1'b1;
          end else if (w_cycles_nx == TIME_LIM) begin
            w_state_nx   = S_TIMEOUT;
            w_timeout_nx = 1'b1;
          end
        end
        default: ;
      endcase
    end
    w_busy_nx = (w_state_nx == S_RUN);
  end

  assign total_o   = r_total;
  assign cycles_o  = r_cycles;
  assign state_o   = r_state;
  assign done_o    = r_done;
  assign stalled_o = r_stalled;
  assign timeout_o = r_timeout;
  assign busy_o    = r_busy;

`ifdef NOC_MON_PER_NODE_EN
  logic [CNT_WIDTH-1:0] r_node_cnt [NODES_NUM];
  logic [CNT_WIDTH-1:0] w_node_nx  [NODES_NUM];

  always_comb begin
    for (int i = 0; i < NODES_NUM; i++) begin
      w_node_nx[i] = r_node_cnt[i];
      if (clear_i || r_state == S_IDLE) begin
        w_node_nx[i] = '0;
      end else if (r_state == S_RUN) begin
        w_node_nx[i] = sat_add(r_node_cnt[i], CNT_WIDTH'(recv_i[i]));
      end
    end
  end

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      for (int i = 0; i < NODES_NUM; i++) r_node_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NODES_NUM; i++) r_node_cnt[i] <= w_node_nx[i];
    end
  end

  for (genvar g = 0; g < NODES_NUM; g++) begin : g_node_out
    assign per_node_o[g*CNT_WIDTH +: CNT_WIDTH] = r_node_cnt[g];
  end
`else
  // Only the aggregate total is kept in this build.
`endif

endmodule

// File: tb/tb_noc_run_monitor.sv
// Directed bench for noc_run_monitor: a per-cycle vector table plus
// hand-written stall, timeout, priority and asynchronous-reset sequences.
module tb_noc_run_monitor;

  localparam int NODES = 16;
  localparam int AW    = 8;
  localparam int CW    = 32;

  logic            clk;
  logic            a_rst;
  logic            start_i;
  logic            clear_i;
  logic [NODES-1:0] recv_i;
  logic [AW-1:0]   act_i;
  logic [CW-1:0]   total_o;
  logic [CW-1:0]   cycles_o;
  logic [2:0]      state_o;
  logic            done_o;
  logic            stalled_o;
  logic            timeout_o;
  logic            busy_o;
`ifdef NOC_MON_PER_NODE_EN
  logic [NODES*CW-1:0] per_node_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  noc_run_monitor #(
    .NODES_NUM(NODES), .ACT_WIDTH(AW), .CNT_WIDTH(CW),
    .PACKS_EXPECTED(64), .STALL_LIMIT(10), .TEST_TIME(20)
  ) dut (
    .clk(clk), .a_rst(a_rst), .start_i(start_i), .clear_i(clear_i),
    .recv_i(recv_i), .act_i(act_i), .total_o(total_o), .cycles_o(cycles_o),
    .state_o(state_o), .done_o(done_o), .stalled_o(stalled_o),
    .timeout_o(timeout_o), .busy_o(busy_o)
`ifdef NOC_MON_PER_NODE_EN
    , .per_node_o(per_node_o)
`endif
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        clear;
    logic [15:0] recv;
    logic [7:0]  act;
    logic [2:0]  e_state;
    logic [31:0] e_total;
    logic [31:0] e_cycles;
    logic        e_done;
    logic        e_stall;
    logic        e_to;
    logic        e_busy;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] st, input logic [31:0] tot,
                           input logic [31:0] cyc, input logic d, input logic s,
                           input logic t, input logic b);
    check({tag, ".state"},   64'(state_o),   64'(st));
    check({tag, ".total"},   64'(total_o),   64'(tot));
    check({tag, ".cycles"},  64'(cycles_o),  64'(cyc));
    check({tag, ".done"},    64'(done_o),    64'(d));
    check({tag, ".stalled"}, 64'(stalled_o), 64'(s));
    check({tag, ".timeout"}, 64'(timeout_o), 64'(t));
    check({tag, ".busy"},    64'(busy_o),    64'(b));
  endtask

  // Drive at the falling edge, sample 1ns after the rising edge.
  task automatic drive(input logic st, input logic cl, input logic [15:0] rv, input logic [7:0] ac);
    @(negedge clk);
    start_i = st;
    clear_i = cl;
    recv_i  = rv;
    act_i   = ac;
    @(posedge clk);
    #1;
  endtask

`ifdef NOC_MON_PER_NODE_EN
  task automatic check_nodes(input string tag, input logic [31:0] exp);
    for (int n = 0; n < NODES; n++) begin
      check($sformatf("%s.node%0d", tag, n), 64'(per_node_o[n*CW +: CW]), 64'(exp));
    end
  endtask
`endif

  initial begin
    //          start clr  recv      act    st  total cyc d  s  t  b
    vecs[0]  = '{1'b1, 1'b0, 16'h0000, 8'h00, 3'd1, 0,  0, 0, 0, 0, 1};
    vecs[1]  = '{1'b0, 1'b0, 16'hFFFF, 8'h01, 3'd1, 16, 1, 0, 0, 0, 1};
    vecs[2]  = '{1'b0, 1'b0, 16'hFFFF, 8'h00, 3'd1, 32, 2, 0, 0, 0, 1};
    vecs[3]  = '{1'b0, 1'b0, 16'hFFFF, 8'h01, 3'd1, 48, 3, 0, 0, 0, 1};
    vecs[4]  = '{1'b0, 1'b0, 16'hFFFF, 8'h00, 3'd2, 64, 4, 1, 0, 0, 0};
    vecs[5]  = '{1'b0, 1'b0, 16'hFFFF, 8'h01, 3'd2, 64, 4, 1, 0, 0, 0};
    vecs[6]  = '{1'b1, 1'b0, 16'h0000, 8'h01, 3'd2, 64, 4, 1, 0, 0, 0};
    vecs[7]  = '{1'b1, 1'b1, 16'hFFFF, 8'h01, 3'd0, 0,  0, 0, 0, 0, 0};
    vecs[8]  = '{1'b1, 1'b0, 16'h0000, 8'h02, 3'd1, 0,  0, 0, 0, 0, 1};
    vecs[9]  = '{1'b0, 1'b0, 16'h0101, 8'h03, 3'd1, 2,  1, 0, 0, 0, 1};
    vecs[10] = '{1'b0, 1'b0, 16'h8001, 8'h04, 3'd1, 4,  2, 0, 0, 0, 1};
    vecs[11] = '{1'b0, 1'b0, 16'h0007, 8'h05, 3'd1, 7,  3, 0, 0, 0, 1};
    vecs[12] = '{1'b0, 1'b1, 16'hFFFF, 8'h06, 3'd0, 0,  0, 0, 0, 0, 0};

    // Reset: start_i held high during reset must be ignored
    a_rst = 1'b0; start_i = 1'b1; clear_i = 1'b0; recv_i = '0; act_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 3'd0, 0, 0, 0, 0, 0, 0);
`ifdef NOC_MON_PER_NODE_EN
    check_nodes("reset", 0);
`endif
    @(negedge clk);
    start_i = 1'b0;
    a_rst   = 1'b1;

    // Vector table
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].start, vecs[i].clear, vecs[i].recv, vecs[i].act);
      check_all($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_total, vecs[i].e_cycles,
                vecs[i].e_done, vecs[i].e_stall, vecs[i].e_to, vecs[i].e_busy);
`ifdef NOC_MON_PER_NODE_EN
      if (i == 4) check_nodes("pulses", 4);
      if (i == 7) check_nodes("cleared", 0);
`endif
    end

    // Stall: last act change at RUN edge 5, stall 10 edges later
    drive(1'b1, 1'b0, 16'h0000, 8'h10);
    for (int k = 1; k <= 5; k++) drive(1'b0, 1'b0, (k == 1) ? 16'h0001 : 16'h0000, 8'(8'h10 + k));
    for (int k = 6; k <= 14; k++) drive(1'b0, 1'b0, 16'h0000, 8'h15);
    check_all("stall_pre", 3'd1, 1, 14, 0, 0, 0, 1);
    drive(1'b0, 1'b0, 16'h0000, 8'h15);
    check_all("stall_hit", 3'd3, 1, 15, 0, 1, 0, 0);
    drive(1'b0, 1'b0, 16'hFFFF, 8'h20);
    check_all("stall_frozen", 3'd3, 1, 15, 0, 1, 0, 0);
    drive(1'b0, 1'b1, 16'h0000, 8'h00);
    check_all("stall_clear", 3'd0, 0, 0, 0, 0, 0, 0);

    // Timeout: act toggles every cycle, no packets
    drive(1'b1, 1'b0, 16'h0000, 8'hAA);
    for (int k = 1; k <= 19; k++) drive(1'b0, 1'b0, 16'h0000, (k % 2 == 1) ? 8'h55 : 8'hAA);
    check_all("to_pre", 3'd1, 0, 19, 0, 0, 0, 1);
    drive(1'b0, 1'b0, 16'h0000, 8'hAA);
    check_all("to_hit", 3'd4, 0, 20, 0, 0, 1, 0);
    drive(1'b0, 1'b1, 16'h0000, 8'h00);
    check_all("to_clear", 3'd0, 0, 0, 0, 0, 0, 0);

    // Priority: total reaches 64 on the same edge stall_cnt reaches 10
    drive(1'b1, 1'b0, 16'h0000, 8'h33);
    for (int k = 1; k <= 9; k++) drive(1'b0, 1'b0, (k <= 3) ? 16'hFFFF : 16'h0000, 8'h33);
    check_all("prio_pre", 3'd1, 48, 9, 0, 0, 0, 1);
    drive(1'b0, 1'b0, 16'hFFFF, 8'h33);
    check_all("prio_hit", 3'd2, 64, 10, 1, 0, 0, 0);
    drive(1'b0, 1'b1, 16'h0000, 8'h00);
    check_all("prio_clear", 3'd0, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a run
    drive(1'b1, 1'b0, 16'h0000, 8'h00);
    drive(1'b0, 1'b0, 16'h000F, 8'h01);
    drive(1'b0, 1'b0, 16'h000F, 8'h02);
    drive(1'b0, 1'b0, 16'h000F, 8'h03);
    check_all("run_mid", 3'd1, 12, 3, 0, 0, 0, 1);
    #2;
    a_rst = 1'b0;
    #1;
    check_all("async_rst", 3'd0, 0, 0, 0, 0, 0, 0);
`ifdef NOC_MON_PER_NODE_EN
    check_nodes("async_rst", 0);
`endif
    @(negedge clk);
    a_rst = 1'b1;
    drive(1'b0, 1'b0, 16'hFFFF, 8'h04);
    check_all("post_rst", 3'd0, 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
